// File: rtl/ibus_stream_target_pkg.sv
// Shared constants and the status word layout for the ibus stream target.
package ibus_stream_target_pkg;

    localparam logic [7:0] STATUS_OFFSET = 8'h80;
    localparam int         WIN_SEL_BIT   = 7;
    localparam int         ST_UNF_BIT    = 15;
    localparam int         ST_OVF_BIT    = 14;
    localparam int         ST_CNT_W      = 7;

    // Bit order matters: unf lands on bit 15 and ovf on bit 14.
    typedef struct packed {
        logic                unf;
        logic                ovf;
        logic [ST_CNT_W-1:0] tx_count;
        logic [ST_CNT_W-1:0] rx_count;
    } status_t;

endpackage

// File: rtl/ibus_stream_target_sync_fifo.sv
// Single-clock FIFO with a combinational head; a pop on a full FIFO frees the slot for a same-cycle push.
module sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count,
    output logic             push_ok,
    output logic             pop_ok
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW-1:0]    rd_ptr_d;
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_d;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign head    = mem_q[rd_ptr_q];
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (push_ok && !pop_ok) begin
            count_d = count_q + 1'b1;
        end else if (pop_ok && !push_ok) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset so it can map onto distributed/block RAM.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/ibus_stream_target.sv
// ibus target bridging a one-page register window to a TX/RX stream pair, with sticky
// overflow/underflow flags and a fixed two-cycle read latency.
module ibus_stream_target
    import ibus_stream_target_pkg::*;
#(
    parameter logic [3:0] PAGE  = 4'h1,
    parameter int         DEPTH = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ibus_wen,
    input  logic [15:0] ibus_wadr,
    input  logic [15:0] ibus32_wdata,
    input  logic        ibus_ren,
    input  logic [15:0] ibus_radr,
    output logic [15:0] ibus32_rdata,
    output logic        tx_valid,
    output logic [15:0] tx_data,
    input  logic        tx_ready,
    input  logic        rx_valid,
    input  logic [15:0] rx_data,
    output logic        rx_ready,
    output logic        irq
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic          wr_page, wr_data, wr_stat;
    logic          rd_page, rd_data, rd_stat;
    logic          tx_push_ok, tx_pop_ok, tx_full, tx_empty;
    logic          rx_push_ok, rx_pop_ok, rx_full, rx_empty;
    logic [15:0]   tx_head, rx_head;
    logic [CW-1:0] tx_count, rx_count;
    status_t       status;
    logic [15:0]   rd_value;

    logic          ovf_q, ovf_d;
    logic          unf_q, unf_d;
    logic          irq_q, irq_d;
    logic          rd_vld_q, rd_vld_d;
    logic [15:0]   rd_buf_q, rd_buf_d;
    logic [15:0]   rdata_q, rdata_d;
    logic          unused_bits;

    assign wr_page = (ibus_wadr[11:8] == PAGE);
    assign wr_data = ibus_wen && wr_page && !ibus_wadr[WIN_SEL_BIT];
    assign wr_stat = ibus_wen && wr_page && (ibus_wadr[7:0] == STATUS_OFFSET);
    assign rd_page = (ibus_radr[11:8] == PAGE);
    assign rd_data = ibus_ren && rd_page && !ibus_radr[WIN_SEL_BIT];
    assign rd_stat = ibus_ren && rd_page && (ibus_radr[7:0] == STATUS_OFFSET);

    sync_fifo #(
        .WIDTH (16),
        .DEPTH (DEPTH)
    ) u_tx_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (wr_data),
        .push_data (ibus32_wdata),
        .pop       (tx_valid && tx_ready),
        .head      (tx_head),
        .full      (tx_full),
        .empty     (tx_empty),
        .count     (tx_count),
        .push_ok   (tx_push_ok),
        .pop_ok    (tx_pop_ok)
    );

    sync_fifo #(
        .WIDTH (16),
        .DEPTH (DEPTH)
    ) u_rx_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (rx_valid && rx_ready),
        .push_data (rx_data),
        .pop       (rd_data),
        .head      (rx_head),
        .full      (rx_full),
        .empty     (rx_empty),
        .count     (rx_count),
        .push_ok   (rx_push_ok),
        .pop_ok    (rx_pop_ok)
    );

    assign tx_valid     = !tx_empty;
    assign tx_data      = tx_head;
    assign rx_ready     = !rx_full;
    assign irq          = irq_q;
    assign ibus32_rdata = rdata_q;
    assign unused_bits  = ^{ibus_wadr[15:12], ibus_radr[15:12], tx_full, tx_pop_ok,
                            rx_empty, rx_push_ok};

    always_comb begin
        status.unf      = unf_q;
        status.ovf      = ovf_q;
        status.tx_count = ST_CNT_W'(tx_count);
        status.rx_count = ST_CNT_W'(rx_count);
    end

    always_comb begin
        ovf_d = ovf_q;
        unf_d = unf_q;
        // Clears are applied first so an error in the same cycle stays visible.
        if (wr_stat && ibus32_wdata[ST_UNF_BIT]) begin
            unf_d = 1'b0;
        end
        if (wr_stat && ibus32_wdata[ST_OVF_BIT]) begin
            ovf_d = 1'b0;
        end
        if (wr_data && !tx_push_ok) begin
            ovf_d = 1'b1;
        end
        if (rd_data && !rx_pop_ok) begin
            unf_d = 1'b1;
        end
        irq_d = ovf_q | unf_q;
    end

    always_comb begin
        rd_value = 16'h0000;
        if (rd_data && rx_pop_ok) begin
            rd_value = rx_head;
        end else if (rd_stat) begin
            rd_value = status;
        end
        rd_vld_d = ibus_ren;
        rd_buf_d = rd_value;
        rdata_d  = rd_vld_q ? rd_buf_q : rdata_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
            irq_q    <= 1'b0;
            rd_vld_q <= 1'b0;
            rd_buf_q <= 16'h0000;
            rdata_q  <= 16'h0000;
        end else begin
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
            irq_q    <= irq_d;
            rd_vld_q <= rd_vld_d;
            rd_buf_q <= rd_buf_d;
            rdata_q  <= rdata_d;
        end
    end

endmodule

// File: tb/tb_ibus_stream_target.sv
// Scoreboard bench for ibus_stream_target: read expectations are queued at issue and
// compared when they emerge two cycles later.
module tb_ibus_stream_target;

    localparam logic [3:0] PAGE  = 4'h1;
    localparam int         DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        ibus_wen;
    logic [15:0] ibus_wadr;
    logic [15:0] ibus32_wdata;
    logic        ibus_ren;
    logic [15:0] ibus_radr;
    logic [15:0] ibus32_rdata;
    logic        tx_valid;
    logic [15:0] tx_data;
    logic        tx_ready;
    logic        rx_valid;
    logic [15:0] rx_data;
    logic        rx_ready;
    logic        irq;

    int checks   = 0;
    int failures = 0;

    logic [15:0] rd_addr_q[$];
    logic [15:0] exp_q[$];
    logic [15:0] tx_model[$];

    ibus_stream_target #(
        .PAGE  (PAGE),
        .DEPTH (DEPTH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .ibus_wen     (ibus_wen),
        .ibus_wadr    (ibus_wadr),
        .ibus32_wdata (ibus32_wdata),
        .ibus_ren     (ibus_ren),
        .ibus_radr    (ibus_radr),
        .ibus32_rdata (ibus32_rdata),
        .tx_valid     (tx_valid),
        .tx_data      (tx_data),
        .tx_ready     (tx_ready),
        .rx_valid     (rx_valid),
        .rx_data      (rx_data),
        .rx_ready     (rx_ready),
        .irq          (irq)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic ibus_write(input logic [15:0] addr, input logic [15:0] data);
        ibus_wen     = 1'b1;
        ibus_wadr    = addr;
        ibus32_wdata = data;
        if (addr[11:8] == PAGE && !addr[7] && tx_model.size() < DEPTH)
            tx_model.push_back(data);
        next_cycle();
        ibus_wen = 1'b0;
        $display("write adr=%04h data=%04h", addr, data);
    endtask

    task automatic rx_push(input logic [15:0] data);
        @(negedge clk);
        checks++;
        if (rx_ready !== 1'b1) begin
            failures++;
            $display("FAIL rx_ready_before_push: got %b expected 1", rx_ready);
        end
        @(posedge clk);
        #1;
        rx_valid = 1'b1;
        rx_data  = data;
        next_cycle();
        rx_valid = 1'b0;
        $display("rx push data=%04h", data);
    endtask

    // Issues every queued read back to back; optionally a data-window write rides along
    // with the first read. Results are popped from exp_q two cycles after issue.
    task automatic do_reads(input string name, input logic first_wen, input logic [15:0] wdat);
        int n;
        logic [15:0] exp;
        n = rd_addr_q.size();
        for (int c = 0; c < n + 2; c++) begin
            ibus_ren  = (c < n);
            ibus_radr = (c < n) ? rd_addr_q[c] : 16'h0000;
            ibus_wen  = (c == 0) && first_wen;
            ibus_wadr = 16'h0100;
            ibus32_wdata = wdat;
            if (c == 0 && first_wen) tx_model.push_back(wdat);
            @(negedge clk);
            if (c >= 2) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL %s: scoreboard empty at read %0d", name, c - 2);
                end else begin
                    exp = exp_q.pop_front();
                    if (ibus32_rdata !== exp) begin
                        failures++;
                        $display("FAIL %s read%0d: rdata=%04h expected %04h", name, c - 2, ibus32_rdata, exp);
                    end else begin
                        $display("read %s #%0d adr=%04h rdata=%04h", name, c - 2, rd_addr_q[c - 2], ibus32_rdata);
                    end
                end
            end
            @(posedge clk);
            #1;
            ibus_wen = 1'b0;
        end
        ibus_ren = 1'b0;
        rd_addr_q.delete();
    endtask

    task automatic drain_tx(input string name);
        int n;
        n = tx_model.size();
        tx_ready = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            checks++;
            if (tx_valid !== 1'b1 || tx_data !== tx_model[0]) begin
                failures++;
                $display("FAIL %s tx%0d: valid=%b data=%04h expected valid=1 data=%04h",
                         name, i, tx_valid, tx_data, tx_model[0]);
            end else begin
                $display("tx %s #%0d data=%04h", name, i, tx_data);
            end
            void'(tx_model.pop_front());
            @(posedge clk);
            #1;
        end
        tx_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (tx_valid !== 1'b0) begin
            failures++;
            $display("FAIL %s tx_empty_after_drain: tx_valid=%b expected 0", name, tx_valid);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        ibus_wen = 1'b0; ibus_wadr = '0; ibus32_wdata = '0;
        ibus_ren = 1'b0; ibus_radr = '0;
        tx_ready = 1'b0; rx_valid = 1'b0; rx_data = '0;
        repeat (3) next_cycle();
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (ibus32_rdata !== 16'h0000 || tx_valid !== 1'b0 || rx_ready !== 1'b1 || irq !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: rdata=%04h tx_valid=%b rx_ready=%b irq=%b expected 0000 0 1 0",
                     ibus32_rdata, tx_valid, rx_ready, irq);
        end else begin
            $display("reset state ok");
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_tx_basic();
        tx_model.delete();
        ibus_write(16'h0100, 16'h1234);
        ibus_write(16'h0101, 16'hABCD);
        drain_tx("tx_basic");
        rd_addr_q.push_back(16'h0180); exp_q.push_back(16'h0000);
        do_reads("tx_basic_status", 1'b0, 16'h0000);
    endtask

    task automatic test_rx_read();
        rx_push(16'h0055);
        rx_push(16'h00AA);
        rd_addr_q.push_back(16'h0180); exp_q.push_back(16'h0002);
        rd_addr_q.push_back(16'h0105); exp_q.push_back(16'h0055);
        rd_addr_q.push_back(16'h0105); exp_q.push_back(16'h00AA);
        do_reads("rx_read", 1'b0, 16'h0000);
        repeat (2) next_cycle();
        checks++;
        if (ibus32_rdata !== 16'h00AA) begin
            failures++;
            $display("FAIL rdata_hold: rdata=%04h expected 00aa", ibus32_rdata);
        end
    endtask

    task automatic test_underflow();
        rd_addr_q.push_back(16'h0110); exp_q.push_back(16'h0000);
        rd_addr_q.push_back(16'h0180); exp_q.push_back(16'h8000);
        do_reads("underflow", 1'b0, 16'h0000);
        checks++;
        if (irq !== 1'b1) begin
            failures++;
            $display("FAIL unf_irq: irq=%b expected 1", irq);
        end
        ibus_write(16'h0180, 16'h8000);
        repeat (2) next_cycle();
        checks++;
        if (irq !== 1'b0) begin
            failures++;
            $display("FAIL unf_clear_irq: irq=%b expected 0", irq);
        end
        rd_addr_q.push_back(16'h0180); exp_q.push_back(16'h0000);
        do_reads("unf_cleared", 1'b0, 16'h0000);
    endtask

    task automatic test_overflow();
        tx_ready = 1'b0;
        for (int i = 0; i < DEPTH + 1; i++) ibus_write(16'h0100 + 16'(i), 16'(i));
        @(negedge clk);
        checks++;
        if (irq !== 1'b0) begin
            failures++;
            $display("FAIL ovf_irq_latency: irq=%b expected 0 one cycle early", irq);
        end
        @(negedge clk);
        checks++;
        if (irq !== 1'b1) begin
            failures++;
            $display("FAIL ovf_irq: irq=%b expected 1", irq);
        end
        @(posedge clk);
        #1;
        rd_addr_q.push_back(16'h0180); exp_q.push_back(16'h4800);
        do_reads("ovf_status", 1'b0, 16'h0000);
        ibus_write(16'h0180, 16'h4000);
        repeat (2) next_cycle();
        checks++;
        if (irq !== 1'b0) begin
            failures++;
            $display("FAIL ovf_clear_irq: irq=%b expected 0", irq);
        end
        rd_addr_q.push_back(16'h0180); exp_q.push_back(16'h0800);
        do_reads("ovf_cleared", 1'b0, 16'h0000);
    endtask

    task automatic test_full_passthrough();
        tx_ready     = 1'b1;
        ibus_wen     = 1'b1;
        ibus_wadr    = 16'h0100;
        ibus32_wdata = 16'hBEEF;
        next_cycle();
        tx_ready = 1'b0;
        ibus_wen = 1'b0;
        void'(tx_model.pop_front());
        tx_model.push_back(16'hBEEF);
        $display("write adr=0100 data=beef with simultaneous tx pop");
        rd_addr_q.push_back(16'h0180); exp_q.push_back(16'h0800);
        do_reads("full_passthrough_status", 1'b0, 16'h0000);
        drain_tx("full_passthrough");
    endtask

    task automatic test_mixed();
        rx_push(16'h0033);
        ibus_write(16'h0200, 16'h9999);
        ibus_write(16'h0181, 16'h9999);
        rd_addr_q.push_back(16'h0180); exp_q.push_back(16'h0001);
        rd_addr_q.push_back(16'h0181); exp_q.push_back(16'h0000);
        rd_addr_q.push_back(16'h0205); exp_q.push_back(16'h0000);
        rd_addr_q.push_back(16'hF105); exp_q.push_back(16'h0033);
        do_reads("mixed", 1'b1, 16'h1111);
        drain_tx("mixed");
    endtask

    task automatic test_reset_midflight();
        ibus_write(16'h0100, 16'h5555);
        rx_push(16'h0077);
        rx_push(16'h0088);
        ibus_ren  = 1'b1;
        ibus_radr = 16'h0100;
        next_cycle();
        next_cycle();
        ibus_ren = 1'b0;
        rst      = 1'b1;
        @(negedge clk);
        checks++;
        if (ibus32_rdata !== 16'h0077) begin
            failures++;
            $display("FAIL midflight_first: rdata=%04h expected 0077", ibus32_rdata);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        tx_model.delete();
        @(negedge clk);
        checks++;
        if (ibus32_rdata !== 16'h0000 || tx_valid !== 1'b0 || rx_ready !== 1'b1) begin
            failures++;
            $display("FAIL midflight_reset: rdata=%04h tx_valid=%b rx_ready=%b expected 0000 0 1",
                     ibus32_rdata, tx_valid, rx_ready);
        end
        @(posedge clk);
        #1;
        next_cycle();
        checks++;
        if (ibus32_rdata !== 16'h0000) begin
            failures++;
            $display("FAIL midflight_discard: rdata=%04h expected 0000", ibus32_rdata);
        end
        rx_push(16'h0099);
        rd_addr_q.push_back(16'h0180); exp_q.push_back(16'h0001);
        do_reads("midflight_status", 1'b0, 16'h0000);
    endtask

    initial begin
        test_reset();
        test_tx_basic();
        test_rx_read();
        test_underflow();
        test_overflow();
        test_full_passthrough();
        test_mixed();
        test_reset_midflight();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
